// File: rtl/down_timer.sv
// Loadable down-counting timer with terminal-count detection.
// The counter decrements once per enabled cycle while running. On expiry it
// emits a one-cycle done pulse, then either reloads (periodic mode) or
// returns to idle at zero (one-shot mode).
module down_timer #(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             auto_reload,
  output logic [Width-1:0] q,
  output logic             min_tick,
  output logic             done,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [Width-1:0] cnt_q, cnt_d;
  logic [Width-1:0] rld_q, rld_d;
  logic             done_q, done_d;

  // Next-state logic: load beats stop, stop beats start, start beats counting.
  // The decrement only happens on a nonzero count, so the counter can never
  // borrow below zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rld_d   = rld_q;
    done_d  = 1'b0;

    if (load) begin
      cnt_d   = load_val;
      rld_d   = load_val;
      state_d = IDLE;
    end else if (state_q == RUN) begin
      if (stop) begin
        state_d = IDLE;
      end else if (en) begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - Width'(1);
        end else begin
          done_d = 1'b1;
          if (auto_reload) begin
            cnt_d = rld_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
    end else begin
      if (start && !stop) begin
        state_d = RUN;
      end
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rld_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rld_q   <= rld_d;
      done_q  <= done_d;
    end
  end

  // Outputs come straight from state; min_tick is a pure decode of the count.
  always_comb begin
    q        = cnt_q;
    min_tick = (cnt_q == '0);
    done     = done_q;
    busy     = (state_q == RUN);
  end

endmodule
